// File: rtl/dmem_arb_pkg.sv
// Shared types and parameter checks for the data-RAM arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  function automatic bit lat_ok(int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  function automatic bit starve_ok(int smax);
    return (smax >= 1) && (smax <= 15);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between CPU and debug, with a bounded CPU-priority streak.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  output logic cpu_gnt_o,
  output logic dbg_gnt_o
);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved   = (starve_q == 4'(STARVE_MAX));
  assign dbg_gnt_o = en_i & dbg_req_i & (~cpu_req_i | starved);
  assign cpu_gnt_o = en_i & cpu_req_i & ~(dbg_req_i & starved);

  // Counts CPU wins only while debug is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (!dbg_req_i || dbg_gnt_o)      starve_d = '0;
    else if (cpu_gnt_o && !starved)   starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data RAM between the CPU MEM stage and a debug port;
// one access in flight at a time, CPU frozen via cpu_stall while pending.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (!lat_ok(LATENCY)) begin : g_bad_latency
    $error("dmem_arbiter: LATENCY must be 1..4");
  end
  if (!starve_ok(STARVE_MAX)) begin : g_bad_starve
    $error("dmem_arbiter: STARVE_MAX must be 1..15");
  end

  state_e            state_q;
  logic              owner_q;
  logic [2:0]        lat_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic idle, done, cpu_gnt, dbg_gnt, win_we, sel_dbg, cpu_rd_done, dbg_rd_done;

  // Reset gates the grant so no strobe escapes while reset is high.
  assign idle = (state_q == S_IDLE) & ~reset;
  assign done = (state_q == S_BUSY) & (lat_q == 3'(LATENCY));

  dmem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk       (clk),
    .reset     (reset),
    .en_i      (idle),
    .cpu_req_i (cpu_req),
    .dbg_req_i (dbg_req),
    .cpu_gnt_o (cpu_gnt),
    .dbg_gnt_o (dbg_gnt)
  );

  assign cpu_rd_done = done & (owner_q == OWN_CPU);
  assign dbg_rd_done = done & (owner_q == OWN_DBG);
  assign win_we      = dbg_gnt ? dbg_we : cpu_we;

  // In BUSY the address keeps following the registered owner.
  assign sel_dbg   = (state_q == S_BUSY) ? (owner_q == OWN_DBG) : dbg_gnt;
  assign ram_en    = cpu_gnt | dbg_gnt;
  assign ram_we    = ram_en & win_we;
  assign ram_addr  = sel_dbg ? dbg_addr  : cpu_addr;
  assign ram_wdata = sel_dbg ? dbg_wdata : cpu_wdata;

  assign cpu_stall = cpu_req & ~reset & ~((cpu_gnt & cpu_we) | cpu_rd_done);
  assign cpu_rdata = cpu_rd_done ? ram_rdata : '0;
  assign dbg_ack   = (dbg_gnt & dbg_we) | dbg_rd_done;
  assign dbg_rdata = dbg_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      lat_q       <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ram_en && !win_we) begin
            state_q <= S_BUSY;
            owner_q <= dbg_gnt ? OWN_DBG : OWN_CPU;
            lat_q   <= 3'd1;
          end
        end
        S_BUSY: begin
          if (done) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            if (owner_q == OWN_DBG) dbg_rdata_q <= ram_rdata;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single synchronous data RAM between two masters: the CPU MEM stage and a debug/program-loader port.
- It sits between the CPU's data-memory interface and the RAM macro.
- Arbitrates, sequences multi-cycle reads, and freezes the CPU pipeline through cpu_stall while the CPU's access is pending.
- Starvation of the debug port is bounded by a counter.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- LATENCY, 1, RAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 4, maximum consecutive CPU grants while dbg_req is pending; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU load/store request; held until cpu_stall is low.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  load data; valid in the cycle the CPU read completes.
- cpu_stall  out  1  CPU must freeze its pipeline and hold its request.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  last debug read data, registered and held.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid LATENCY cycles after a read strobe.

Behaviour:
- Reset values:
  - FSM = IDLE, owner = CPU, lat_cnt = 0, starve_cnt = 0, dbg_rdata = 0.
  - While reset is high: ram_en = 0, ram_we = 0, dbg_ack = 0, cpu_stall = 0.
- FSM states:
  - IDLE: no access outstanding.
  - BUSY: a read is outstanding; owner is registered.
- Grant decision (IDLE, combinational):
  - Only one request present: that requester wins.
  - Both present: CPU wins unless starve_cnt == STARVE_MAX, in which case dbg wins.
- Issue (IDLE, same cycle as the grant):
  - ram_en = 1; ram_we, ram_addr and ram_wdata are muxed from the winner.
- Write:
  - Completes in the issue cycle; FSM stays in IDLE.
  - CPU winner: cpu_stall = 0 that cycle.
  - dbg winner: dbg_ack = 1 that cycle.
- Read:
  - Issue cycle: FSM -> BUSY, lat_cnt = 1, owner latched.
  - In BUSY: lat_cnt increments each cycle; ram_en = 0; ram_addr holds the owner's address.
  - Completion cycle is when lat_cnt == LATENCY:
    - CPU owner: cpu_rdata = ram_rdata (combinational pass-through) and cpu_stall = 0.
    - dbg owner: dbg_ack = 1 and dbg_rdata <= ram_rdata.
    - FSM -> IDLE at the next edge.
  - CPU read latency is therefore LATENCY+1 cycles including the issue cycle, i.e. LATENCY stall cycles.
- cpu_stall: equals cpu_req AND NOT (CPU completion this cycle). It is asserted whenever the CPU is losing arbitration, waiting in BUSY, or another master owns the RAM.
- cpu_rdata: 0 outside CPU read completion cycles.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each CPU grant while dbg_req = 1.
  - Clears on any dbg grant, or in any cycle with dbg_req = 0.
- No pipelining: at most one outstanding access. A new issue is only possible in the cycle after a read completion.
- Boundary cases:
  - cpu_req or dbg_req rising while BUSY: waits; evaluated in IDLE.
  - dbg_req dropped before dbg_ack: protocol violation. The outstanding read still completes and dbg_rdata updates; dbg_ack still pulses.
  - Reset asserted in BUSY: the outstanding read is abandoned; no ack or stall release is generated; state returns to the reset values immediately.
  - LATENCY = 1: BUSY lasts exactly one cycle.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the owner encoding (OWN_CPU = 0, OWN_DBG = 1);
  - the legal-range checks for LATENCY and STARVE_MAX.
- One sub-module, dmem_arb_pick: combinational winner selection plus the starve_cnt register and its update.
- The top level holds the FSM, lat_cnt, muxes and dbg_rdata register.

Test Plan:
- CPU store only: cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF, LATENCY=1.
  -> Same cycle: ram_en=1, ram_we=1, ram_addr=0x10, ram_wdata=0xDEADBEEF, cpu_stall=0.
- CPU load, LATENCY=3, RAM returns 0x1234 after 3 cycles.
  -> cpu_stall high for exactly 3 cycles, then low with cpu_rdata=0x1234.
  -> Next cycle FSM is IDLE.
- Contention: cpu_req held continuously issuing stores, dbg_req=1 from cycle 0, STARVE_MAX=4.
  -> 4 CPU grants, then the 5th is a dbg grant with dbg_ack=1 and cpu_stall=1 that cycle.
  -> starve_cnt clears.
- Debug read, addr 0x40, RAM data 0xCAFE0001, LATENCY=2.
  -> dbg_ack pulses 1 cycle at completion.
  -> dbg_rdata=0xCAFE0001 and held afterwards.
- cpu_req asserted while a dbg read is BUSY.
  -> cpu_stall=1 until the dbg completion; the CPU issue occurs the following cycle.
- Reset pulsed in the 2nd BUSY cycle of a CPU load (LATENCY=4).
  -> Immediately ram_en=0, cpu_stall=0, dbg_ack=0.
  -> After release: FSM IDLE, no stale completion.
